// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage request and HI/LO result bundle of the multiply/divide unit.
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS mult/multu/div/divu and mthi/mtlo with committed HI/LO.
module mult_div_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic clk,
    input logic reset,
    mult_div_unit_if.slave bus
);
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
    localparam logic [3:0] MC = 4'(MULT_CYC), DC = 4'(DIV_CYC);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic busy, busy_n;
    logic [31:0] hi, hi_n, lo, lo_n, hi_tmp, hi_tmp_n, lo_tmp, lo_tmp_n;
    logic [63:0] prod_s, prod_u;
    logic [31:0] dvs, q_s, r_s, q_u, r_u, res_hi, res_lo;
    logic dz, ovf, is_mul, is_div;
    assign is_mul = bus.MDOp == OP_MULT || bus.MDOp == OP_MULTU;
    assign is_div = bus.MDOp == OP_DIV || bus.MDOp == OP_DIVU;
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign dz = bus.B == 32'd0;
    assign ovf = bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF;
    // Safe divisor keeps the dividers away from divide-by-zero and signed overflow.
    assign dvs = (dz || ovf) ? 32'd1 : bus.B;
    assign q_s = $signed(bus.A) / $signed(dvs);
    assign r_s = $signed(bus.A) % $signed(dvs);
    assign q_u = bus.A / dvs;
    assign r_u = bus.A % dvs;
    // A zero divisor commits the current HI/LO, which cannot change while running.
    assign res_hi = bus.MDOp == OP_MULT  ? prod_s[63:32] :
                    bus.MDOp == OP_MULTU ? prod_u[63:32] :
                    dz                   ? hi :
                    bus.MDOp == OP_DIV   ? (ovf ? 32'd0 : r_s) : r_u;
    assign res_lo = bus.MDOp == OP_MULT  ? prod_s[31:0] :
                    bus.MDOp == OP_MULTU ? prod_u[31:0] :
                    dz                   ? lo :
                    bus.MDOp == OP_DIV   ? (ovf ? 32'h8000_0000 : q_s) : q_u;
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        busy_n   = busy;
        hi_n     = hi;
        lo_n     = lo;
        hi_tmp_n = hi_tmp;
        lo_tmp_n = lo_tmp;
        if (state == IDLE) begin
            if (bus.Start && (is_mul || is_div)) begin
                hi_tmp_n = res_hi;
                lo_tmp_n = res_lo;
                cnt_n    = is_div ? DC : MC;
                busy_n   = 1'b1;
                state_n  = RUN;
            end else if (bus.Start && bus.MDOp == OP_MTHI) begin
                hi_n = bus.A;
            end else if (bus.Start && bus.MDOp == OP_MTLO) begin
                lo_n = bus.A;
            end
        end else begin
            cnt_n = cnt - 4'd1;
            if (cnt <= 4'd1) begin
                hi_n    = hi_tmp;
                lo_n    = lo_tmp;
                cnt_n   = 4'd0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            busy   <= busy_n;
            hi     <= hi_n;
            lo     <= lo_n;
            hi_tmp <= hi_tmp_n;
            lo_tmp <= lo_tmp_n;
        end
    end
    assign bus.Busy = busy;
    assign bus.HI   = hi;
    assign bus.LO   = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO and busy-length expectations.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int checks = 0, failures = 0;
    int n;
    mult_div_unit_if bus ();
    mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Called at a negedge; returns at the next negedge with Start low again.
    task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.MDOp = op;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask
    task automatic busy_len(output int len);
        len = 0;
        while (bus.Busy === 1'b1 && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.MDOp = 3'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        pulse(3'd1, 32'hFFFF_FFFE, 32'd3);
        busy_len(n);
        check("mult_cyc", n, 32'd5);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFFA);
        pulse(3'd2, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        check("multu_cyc", n, 32'd5);
        check("multu_hi", bus.HI, 32'h0000_0001);
        check("multu_lo", bus.LO, 32'hFFFF_FFFE);
        pulse(3'd3, 32'hFFFF_FFF9, 32'd2);
        busy_len(n);
        check("div_cyc", n, 32'd10);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        pulse(3'd4, 32'd7, 32'd0);
        busy_len(n);
        check("divz_cyc", n, 32'd10);
        check("divz_hi", bus.HI, 32'hFFFF_FFFF);
        check("divz_lo", bus.LO, 32'hFFFF_FFFD);
        pulse(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        check("ovf_cyc", n, 32'd10);
        check("ovf_hi", bus.HI, 32'h0000_0000);
        check("ovf_lo", bus.LO, 32'h8000_0000);
        pulse(3'd0, 32'h5555_5555, 32'd9);
        check("noop_busy", 32'(bus.Busy), 32'd0);
        check("noop_hi", bus.HI, 32'h0000_0000);
        check("noop_lo", bus.LO, 32'h8000_0000);
        pulse(3'd5, 32'h1234_5678, 32'd0);
        check("mthi_busy", 32'(bus.Busy), 32'd0);
        check("mthi_hi", bus.HI, 32'h1234_5678);
        pulse(3'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_busy", 32'(bus.Busy), 32'd0);
        check("mtlo_lo", bus.LO, 32'h9ABC_DEF0);
        check("mtlo_hi", bus.HI, 32'h1234_5678);
        pulse(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        pulse(3'd5, 32'h0000_DEAD, 32'd0);
        busy_len(n);
        check("ign_cyc", n, 32'd3);
        check("ign_hi", bus.HI, 32'd0);
        check("ign_lo", bus.LO, 32'd12);
        pulse(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_hi", bus.HI, 32'd0);
        check("abort_lo", bus.LO, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(bus.Busy), 32'd0);
        check("abort_lo2", bus.LO, 32'd0);
        pulse(3'd4, 32'd100, 32'd7);
        busy_len(n);
        check("divu_cyc", n, 32'd10);
        check("divu_hi", bus.HI, 32'd2);
        check("divu_lo", bus.LO, 32'd14);
        reset = 1'b1;
        pulse(3'd6, 32'hCAFE_F00D, 32'd0);
        reset = 1'b0;
        check("prio_lo", bus.LO, 32'd0);
        check("prio_busy", 32'(bus.Busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous reset, active high.
REQ-004 Port: Start  input  1  one-cycle pulse from the E stage that launches the operation selected by MDOp.
REQ-005 Port: MDOp  input  3  operation select: 3'd1 mult, 3'd2 multu, 3'd3 div, 3'd4 divu, 3'd5 mthi, 3'd6 mtlo, others no-op.
REQ-006 Port: A  input  32  rs operand (forwarded value).
REQ-007 Port: B  input  32  rt operand (forwarded value).
REQ-008 Port: Busy  output  1  registered flag, high while an operation is in flight; the stall unit ORs it with Start to form HILO_Busy.
REQ-009 Port: HI  output  32  committed HI register.
REQ-010 Port: LO  output  32  committed LO register.
REQ-011 Parameter: MULT_CYC, default 5, busy cycles for mult/multu.
REQ-012 Parameter: DIV_CYC, default 10, busy cycles for div/divu.

Function
REQ-013 The state machine SHALL have two states, IDLE and RUN, plus a 4-bit down-counter and 32-bit result holding registers hi_tmp/lo_tmp.
REQ-014 In IDLE, Start with MDOp in {mult, multu, div, divu} SHALL compute the result from A and B in that cycle, latch it into hi_tmp/lo_tmp, load the counter with MULT_CYC or DIV_CYC, set Busy=1 at the next edge, and go to RUN.
REQ-015 mult SHALL form the signed 64-bit product; multu SHALL form the unsigned 64-bit product; {hi_tmp,lo_tmp} = product.
REQ-016 div/divu SHALL set lo_tmp = quotient and hi_tmp = remainder; signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-017 For signed 0x80000000 / 0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0x00000000.
REQ-018 If B==0 for div/divu, the block SHALL still run DIV_CYC busy cycles, and HI/LO SHALL remain unchanged at completion.
REQ-019 In RUN, the counter SHALL decrement each cycle; on the cycle the counter reaches 1, the next edge SHALL write HI<=hi_tmp and LO<=lo_tmp, clear Busy, and return to IDLE.
REQ-020 Busy SHALL therefore be high for exactly MULT_CYC or DIV_CYC consecutive cycles, starting the cycle after Start.
REQ-021 HI/LO SHALL show the new result in the first cycle Busy is low.
REQ-022 In IDLE, Start with mthi SHALL write HI<=A at the next edge, and mtlo SHALL write LO<=A; Busy SHALL stay 0.
REQ-023 Start asserted in RUN, for any MDOp, SHALL be ignored: no restart, and HI/LO SHALL not change.
REQ-024 Start with a no-op MDOp SHALL change nothing.
REQ-025 With Start low, HI/LO SHALL hold and the state SHALL not change, except for RUN counting.

Reset
REQ-026 At a clock edge with reset=1, the block SHALL set HI=0, LO=0, Busy=0, counter=0, hi_tmp/lo_tmp=0 and state=IDLE, regardless of Start.
REQ-027 Reset during RUN SHALL abort the operation with no HI/LO write; Busy SHALL be 0 in the first cycle after reset deasserts.
REQ-028 Reset SHALL take priority over Start in the same cycle.

Verification
REQ-029 Directed scenario: mult with A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 Directed scenario: multu with A=0xFFFFFFFF, B=2 -> Busy high for 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 Directed scenario: div with A=-7 (0xFFFFFFF9), B=2 -> Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> 10 busy cycles and HI/LO unchanged.
REQ-032 Directed scenario: mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on the next cycle -> Busy stays 0; HI=0x12345678 and LO=0x9ABCDEF0 one edge after each.
REQ-033 Directed scenario: mult 3*4, then Start with mthi A=0xDEAD during the 2nd busy cycle -> the mthi is ignored; after 5 cycles HI=0, LO=12.
REQ-034 Directed scenario: div 100/7 with reset pulsed in the 4th busy cycle -> HI=LO=0 and Busy=0 after reset; a following divu 100/7 gives LO=14, HI=2 after 10 cycles.
